// File: rtl/picosoc_pkg.sv
// Shared definitions for the PicoSoC BRAM: FSM encodings, clog2 helper and
// parameter legality predicates used at elaboration time.
package picosoc_pkg;

  // FSM encodings
  localparam logic [1:0] ST_CLEAR = 2'd0;
  localparam logic [1:0] ST_IDLE  = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  // Deepest supported read pipeline
  localparam int MAX_READ_LATENCY = 4;

  // Flags of the accepted request that are still needed at response time
  typedef struct packed {
    logic rd;   // access was a read
    logic oob;  // word index fell outside the array
  } req_flags_t;

  // Ceiling log2; clog2(1) = 0
  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r++;
      x = x >> 1;
    end
    return r;
  endfunction

  function automatic bit read_latency_ok(input int rl);
    return (rl >= 1) && (rl <= MAX_READ_LATENCY);
  endfunction

  function automatic bit data_width_ok(input int dw);
    return (dw >= 8) && (dw % 8 == 0);
  endfunction

endpackage

// File: rtl/picosoc_bram_lane.sv
// One byte lane of the BRAM: 8-bit x WORDS array, single write port and a
// registered synchronous read port. No reset, so it maps onto block RAM.
module picosoc_bram_lane #(
  parameter int WORDS = 512,
  parameter int AW    = 9
) (
  input  logic          clk,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata
);

  logic [7:0] mem [0:WORDS-1];

  // Write port; contents survive reset
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  // Registered read, only updated on a read strobe so the word stays
  // available for the whole latency window
  always_ff @(posedge clk) begin
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/picosoc_bram.sv
// PicoSoC on-chip RAM on the PicoRV32 native memory bus. Byte-lane array
// built from NB lane instances, configurable read latency, out-of-range
// detection and an optional zero-fill sweep after every reset.
module picosoc_bram
  import picosoc_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int WORDS          = 512,
  parameter int ADDR_WIDTH     = 22,
  parameter int READ_LATENCY   = 1,
  parameter int CLEAR_ON_RESET = 0
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    mem_valid,
  output logic                    mem_ready,
  input  logic [ADDR_WIDTH-1:0]   mem_addr,
  input  logic [DATA_WIDTH-1:0]   mem_wdata,
  input  logic [DATA_WIDTH/8-1:0] mem_wstrb,
  output logic [DATA_WIDTH-1:0]   mem_rdata,
  output logic                    busy,
  output logic                    oob_err
);

  localparam int NB = DATA_WIDTH / 8;
  localparam int BW = clog2(NB);                              // byte-offset bits
  localparam int FW = ADDR_WIDTH - BW;                        // full index width
  localparam int IW = (clog2(WORDS) < 1) ? 1 : clog2(WORDS);  // stored index width

  if (!read_latency_ok(READ_LATENCY)) begin : g_bad_rl
    $error("picosoc_bram: READ_LATENCY must be in 1..4");
  end
  if (!data_width_ok(DATA_WIDTH)) begin : g_bad_dw
    $error("picosoc_bram: DATA_WIDTH must be a multiple of 8, at least 8");
  end

  logic [1:0]            state;
  logic [IW-1:0]         clr_cnt;
  logic [1:0]            wait_cnt;
  req_flags_t            flags;
  logic [DATA_WIDTH-1:0] out_q;

  logic [FW-1:0]         full_idx;
  logic [IW-1:0]         idx;
  logic                  in_oob;
  logic                  is_wr;
  logic                  accept;

  logic [IW-1:0]         lane_addr;
  logic [DATA_WIDTH-1:0] lane_wdata;
  logic [NB-1:0]         lane_we;
  logic                  lane_re;
  logic [DATA_WIDTH-1:0] lane_q;
  logic [DATA_WIDTH-1:0] rsp_data;

  // Byte-offset bits select nothing inside a word
  if (BW > 0) begin : g_lowbits
    logic unused_lowbits;
    assign unused_lowbits = ^mem_addr[BW-1:0];
  end

  // Range check uses the full index; the array only sees the truncated one
  assign full_idx = mem_addr[ADDR_WIDTH-1:BW];
  assign idx      = IW'(full_idx);
  assign in_oob   = 64'(full_idx) >= 64'(WORDS);
  assign is_wr    = |mem_wstrb;
  assign accept   = resetn && (state == ST_IDLE) && mem_valid;

  // Lane port mux: the clear sweep owns the lanes, otherwise the bus does.
  // Writes and read strobes are gated by resetn so reset never touches the
  // array, and by the range check so out-of-range accesses are harmless.
  always_comb begin
    lane_addr  = idx;
    lane_wdata = mem_wdata;
    lane_we    = (accept && !in_oob) ? mem_wstrb : '0;
    lane_re    = accept && !is_wr && !in_oob;
    if (state == ST_CLEAR) begin
      lane_addr  = clr_cnt;
      lane_wdata = '0;
      lane_we    = resetn ? '1 : '0;
      lane_re    = 1'b0;
    end
  end

  for (genvar i = 0; i < NB; i++) begin : g_lane
    picosoc_bram_lane #(
      .WORDS (WORDS),
      .AW    (IW)
    ) u_lane (
      .clk   (clk),
      .we    (lane_we[i]),
      .re    (lane_re),
      .addr  (lane_addr),
      .wdata (lane_wdata[8*i +: 8]),
      .rdata (lane_q[8*i +: 8])
    );
  end

  // Request FSM: clear sweep, acceptance, read latency countdown, response
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
      clr_cnt  <= '0;
      wait_cnt <= '0;
      flags    <= '0;
      out_q    <= '0;
    end else begin
      case (state)
        ST_CLEAR: begin
          if (clr_cnt == IW'(WORDS - 1)) state <= ST_IDLE;
          else                           clr_cnt <= clr_cnt + 1'b1;
        end
        ST_IDLE: begin
          if (mem_valid) begin
            flags.rd  <= !is_wr;
            flags.oob <= in_oob;
            if (is_wr || READ_LATENCY == 1) begin
              state <= ST_RESP;
            end else begin
              state    <= ST_WAIT;
              wait_cnt <= (READ_LATENCY >= 2) ? 2'(READ_LATENCY - 2) : 2'd0;
            end
          end
        end
        ST_WAIT: begin
          if (wait_cnt == 2'd0) state <= ST_RESP;
          else                  wait_cnt <= wait_cnt - 2'd1;
        end
        ST_RESP: begin
          // Latch the presented read word so it holds until the next read
          if (flags.rd) out_q <= rsp_data;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // The lane registers still hold the word during the response cycle; show
  // it directly then, and the held copy at all other times.
  assign rsp_data  = flags.oob ? '0 : lane_q;
  assign mem_rdata = (state == ST_RESP && flags.rd) ? rsp_data : out_q;
  assign mem_ready = (state == ST_RESP);
  assign oob_err   = (state == ST_RESP) && flags.oob;
  assign busy      = (state == ST_CLEAR);

endmodule

// File: doc/picosoc_bram.md
Name: picosoc_bram

Overview:
- Parametrised on-chip RAM for the PicoSoC fabric, the next generation of the plain byte-lane BRAM.
- Connects directly to the PicoRV32 native memory bus (mem_valid/mem_ready handshake) instead of raw wen/addr, so no external glue is needed.
- Adds configurable data width, depth, read latency, out-of-range detection and an optional zero-fill after reset.
- Used as main/scratch RAM behind the SoC address decoder.

Parameters:
- DATA_WIDTH, 32, bus width in bits; multiple of 8, at least 8; NB = DATA_WIDTH/8 byte lanes.
- WORDS, 512, depth in words; need not be a power of two.
- ADDR_WIDTH, 22, width of the byte address on mem_addr.
- READ_LATENCY, 1, cycles from acceptance to read response; legal range 1..4.
- CLEAR_ON_RESET, 0, 1 = zero-fill the whole array after every reset.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- resetn  in  1  synchronous, active-low reset.
- mem_valid  in  1  request valid; the master holds it and all request fields stable until mem_ready.
- mem_ready  out  1  one-cycle completion pulse.
- mem_addr  in  ADDR_WIDTH  byte address; word index = mem_addr[ADDR_WIDTH-1:log2(NB)]; low bits ignored.
- mem_wdata  in  DATA_WIDTH  write data.
- mem_wstrb  in  NB  byte write enables; all zero = read.
- mem_rdata  out  DATA_WIDTH  read data; valid while mem_ready=1.
- busy  out  1  zero-fill in progress.
- oob_err  out  1  pulses together with mem_ready when the word index >= WORDS.

Behaviour:
- Reset state (resetn=0 at a clock edge):
  - mem_ready=0, mem_rdata=0, oob_err=0.
  - busy=CLEAR_ON_RESET.
  - FSM goes to CLEAR if CLEAR_ON_RESET=1, otherwise IDLE.
  - Array contents are untouched by reset.
- FSM states: CLEAR, IDLE, WAIT, RESP.
- CLEAR:
  - A counter runs from 0 to WORDS-1, writing all-zero to all lanes, one word per cycle.
  - mem_valid is ignored; the request stays pending and the master keeps waiting.
  - After the write to word WORDS-1: busy falls and the FSM goes to IDLE, i.e. busy is high for exactly WORDS cycles after reset release.
- Acceptance: in IDLE with mem_valid=1 at edge T the request is accepted; address, wstrb and wdata are captured into internal registers.
- Write (wstrb != 0):
  - Lanes with wstrb[i]=1 are written at edge T; other lanes keep their value.
  - Goes to RESP; mem_ready=1 in cycle T+1.
  - mem_rdata is unchanged by a write.
- Read:
  - Synchronous array read at edge T, then READ_LATENCY-1 extra pipeline stages (WAIT, with a down-counter).
  - mem_ready=1 and mem_rdata valid in cycle T+READ_LATENCY.
  - mem_rdata holds its value until the next read completes.
- RESP: lasts one cycle, then IDLE. A request is never accepted in the cycle mem_ready is high. Throughput is at best one access every 2 cycles (writes and READ_LATENCY=1), READ_LATENCY+1 cycles for reads.
- Out of range (word index >= WORDS):
  - Write: no lane is written.
  - Read: returns all zero.
  - Normal latency and mem_ready still apply; oob_err=1 in the same cycle as mem_ready.
  - Address bits above the index range are not decoded here (the SoC decoder selects this block).
- mem_valid dropping before mem_ready is a master protocol violation. The accepted access still completes; behaviour with respect to the master is undefined. The bench flags it as an error.
- Reset mid-operation: a pending access is abandoned with no mem_ready; a write already performed at edge T stays. An interrupted clear restarts from word 0.
- Width rules: the address is truncated to ADDR_WIDTH; the index register is clog2(WORDS) wide, and the range compare uses the full untruncated index.

Decomposition:
- Shared package/header picosoc_pkg holds:
  - FSM state encodings (CLEAR, IDLE, WAIT, RESP);
  - the clog2 helper function;
  - the READ_LATENCY legality check (elaboration error outside 1..4).
- Sub-module picosoc_bram_lane: one 8-bit x WORDS array with a single write enable and a registered synchronous read; instantiated NB times via generate.
- The CLEAR path muxes the lane write address and data in front of the lanes.

Test Plan:
- Word write/read, DATA_WIDTH=32: write addr 0x10 data 0xDEADBEEF wstrb 4'hF, then read 0x10 -> write ready at T+1; read ready at T+1 with rdata 0xDEADBEEF.
- Byte strobes: write 0x11223344 to addr 0x20 with wstrb 4'hF, then 0xAABBCCDD with wstrb 4'b0101, read 0x20 -> rdata 0x11BB33DD.
- READ_LATENCY=3: read accepted at T -> mem_ready first high at T+3, for exactly 1 cycle; mem_rdata stable until the next read.
- OOB, WORDS=512: write to byte addr 0x800 (index 512), then read 0x800 -> oob_err and mem_ready together on each access; read gives 0; word 0 unchanged.
- CLEAR_ON_RESET=1, WORDS=16: fill the array with 0xFF, pulse resetn, assert mem_valid read of addr 0x0 immediately -> busy high 16 cycles; ready only after busy falls; rdata 0.
- Reset mid-read, READ_LATENCY=4: resetn=0 at T+2 -> mem_ready never asserted for that access; mem_rdata=0; the next read after reset completes normally.
